mag_search: RTL and testbench
=============================

# mag_search

Successive-approximation search controller: the driving end of the `mag_comp` interface. It sources the comparator's `A` operand (`guess`) and consumes its `A_gt_b` / `A_lt_b` / `A_eq_b` flags. From these it finds the unknown value on the comparator's `B` operand by binary search, MSB first. It sits beside a combinational `mag_comp` instance and reports the recovered value, a verified-match flag and a comparator-fault flag.

## Interface
- `WIDTH`, default 4: operand width; must match the attached comparator.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a search; sampled only in IDLE.
- `guess` out WIDTH: registered trial value; drives comparator `A`.
- `cmp_gt` in 1: comparator `A_gt_b` for the current `guess`.
- `cmp_lt` in 1: comparator `A_lt_b` for the current `guess`.
- `cmp_eq` in 1: comparator `A_eq_b` for the current `guess`.
- `busy` out 1: high in SEARCH and CHECK.
- `done` out 1: one-cycle completion pulse, high during DONE.
- `result` out WIDTH: recovered value; holds until the next accepted `start`.
- `found` out 1: equality confirmed by the comparator; holds like `result`.
- `err` out 1: comparator flags were not one-hot; holds until the next accepted `start`.

## Operation
- States: IDLE, SEARCH, CHECK, DONE. Internal bit index `k` (0..WIDTH-1) and accumulator `acc`.
- IDLE with `start`=1 at an edge:
  - → SEARCH.
  - `k`=WIDTH-1, `acc`=0, `guess`=1<<(WIDTH-1).
  - Clear `result`, `found` and `err`.
- SEARCH, each edge, the flags are sampled against the current `guess`:
  - `cmp_eq`: `result`=`guess`, `found`=1, → DONE (early exit).
  - `cmp_lt`: bit `k` is kept, `acc`=`guess`.
  - `cmp_gt`: bit `k` is cleared, `acc` unchanged.
  - After `lt`/`gt` with `k`>0: `k`=`k`-1, `guess`=`acc`|(1<<(`k`-1)) using the new `acc`.
  - After `lt`/`gt` with `k`=0: `guess`=new `acc`, → CHECK.
- CHECK, one edge:
  - `result`=`guess`, `found`=`cmp_eq`, → DONE.
  - `found`=0 here means the comparator is inconsistent with the search (not-found); `err` is not set.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- Fault: in SEARCH or CHECK, if {`cmp_gt`,`cmp_lt`,`cmp_eq`} is not exactly one-hot at a sampling edge:
  - `err`=1, `found`=0, `result`=0, → DONE.
- `start` is ignored in SEARCH, CHECK and DONE. No queuing.
- `guess` holds its last value in IDLE and DONE.
- All arithmetic is unsigned, WIDTH bits. There is no carry or wrap: bits are only set or cleared.

## Timing
- Reset values: `guess`=0, `result`=0, `found`=0, `err`=0, `busy`=0, `done`=0, state IDLE. Reset is honoured mid-search and aborts with no `done` pulse.
- The comparator is combinational. Flags are sampled at the edge following each `guess` update, so there is one probe per cycle.
- Latency, counted from the edge accepting `start` (E0) to `done` high:
  - Equality at probe i (1..WIDTH): `done` is high in the cycle after edge Ei.
  - No early equality: WIDTH probes plus CHECK, so `done` is high after E(WIDTH+1).
  - WIDTH=4 worst case: `done` is high in the 6th cycle after E0.
- `busy` falls on the same edge that `done` rises.
- `result`/`found`/`err` are valid from the `done` cycle onward.
- Earliest next accept: `start` is sampled at the first edge after the DONE cycle.

## Test plan
- B=5: `guess` sequence 8,4,6,5; eq at probe 4 → `result`=5, `found`=1, `done` one cycle after E4, `err`=0.
- B=8: eq at probe 1 → `result`=8, `found`=1, `done` after E1, `busy` high for exactly 1 cycle.
- B=0: `guess` sequence 8,4,2,1, then CHECK with `guess`=0 and eq → `result`=0, `found`=1, `done` after E5.
- B=15 and B=7: sequences 8,12,14,15 and 8,4,6,7 → `found`=1 with the correct `result`. Then sweep all B 0..15 against a behavioural comparator: every run has `found`=1, `result`=B, latency ≤6.
- Fault: force `cmp_gt`=`cmp_lt`=1 at probe 2 → `err`=1, `found`=0, `result`=0, single `done` pulse. The next `start` clears `err`.
- Protocol:
  - `start` held high throughout a search → no restart; a new search begins only at the edge after DONE.
  - `rst_n`=0 at probe 3 → next cycle all outputs are at reset values, no `done` pulse.

Source files
------------

// File: rtl/mag_search_if.sv
// Bundle between the search controller and its surroundings: the start/done
// handshake, the reported outcome, and the trial/flag pair shared with mag_comp.
interface mag_search_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] guess;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    modport master (
        input  start, cmp_gt, cmp_lt, cmp_eq,
        output guess, busy, done, result, found, err
    );

    modport slave (
        output start, cmp_gt, cmp_lt, cmp_eq,
        input  guess, busy, done, result, found, err
    );
endinterface

// File: rtl/mag_search.sv
// Successive-approximation search: probes a combinational magnitude comparator
// MSB first to recover its B operand, then reports value, match and fault flags.
module mag_search #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mag_search_if.master bus
);

    localparam int K_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state;
    logic [K_W-1:0]   k;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] guess_q;
    logic [WIDTH-1:0] result_q;
    logic             found_q;
    logic             err_q;

    logic             flags_ok;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] probe_bit;

    // A healthy comparator asserts exactly one of gt/lt/eq for any guess.
    always_comb begin
        flags_ok  = ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} == 3'b100) ||
                    ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} == 3'b010) ||
                    ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} == 3'b001);
        acc_next  = bus.cmp_lt ? guess_q : acc;
        probe_bit = WIDTH'(1) << (k - K_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            acc      <= '0;
            guess_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= SEARCH;
                        k        <= K_W'(WIDTH - 1);
                        acc      <= '0;
                        guess_q  <= WIDTH'(1) << (WIDTH - 1);
                        result_q <= '0;
                        found_q  <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (!flags_ok) begin
                        err_q    <= 1'b1;
                        found_q  <= 1'b0;
                        result_q <= '0;
                        state    <= DONE;
                    end else if (bus.cmp_eq) begin
                        result_q <= guess_q;
                        found_q  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        acc <= acc_next;
                        if (k != '0) begin
                            k       <= k - K_W'(1);
                            guess_q <= acc_next | probe_bit;
                        end else begin
                            // All bits decided without a match; confirm the final value once.
                            guess_q <= acc_next;
                            state   <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (!flags_ok) begin
                        err_q    <= 1'b1;
                        found_q  <= 1'b0;
                        result_q <= '0;
                    end else begin
                        result_q <= guess_q;
                        found_q  <= bus.cmp_eq;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = (state == SEARCH) || (state == CHECK);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_mag_search.sv
// Bench for mag_search: a behavioural comparator with fault injection, a table
// of directed searches, a full sweep, random runs, and protocol corner cases.
module tb_mag_search;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [W-1:0] b_val = '0;
    logic         fault_on = 1'b0;
    logic [2:0]   fault_pat = 3'b000;

    int n_compared = 0;
    int n_mismatch = 0;

    int obs_guesses[$];
    int obs_busy, obs_done, obs_lat, obs_result, obs_found, obs_err;

    mag_search_if #(.WIDTH(W)) bus ();

    mag_search #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Comparator seen by the DUT; fault_on replaces its flags with a chosen pattern.
    always_comb begin
        if (fault_on) begin
            {bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} = fault_pat;
        end else begin
            bus.cmp_gt = (bus.guess > b_val);
            bus.cmp_lt = (bus.guess < b_val);
            bus.cmp_eq = (bus.guess == b_val);
        end
    end

    // Probe i keeps the top i-1 bits of B and tries a 1 in the next position down.
    function automatic int model_guess(input int b, input int i);
        if (i > W) return b;
        return (b & ~((1 << (W - i + 1)) - 1)) | (1 << (W - i));
    endfunction

    function automatic int model_latency(input int b);
        for (int i = 1; i <= W; i++)
            if (model_guess(b, i) == b) return i;
        return W + 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Runs one search; fp>0 replaces the flags with fpat while probe fp is on the bus.
    task automatic applyStimulus(input logic [W-1:0] b, input int fp, input logic [2:0] fpat);
        b_val = b;
        fault_pat = fpat;
        fault_on = 1'b0;
        obs_guesses.delete();
        obs_busy = 0; obs_done = 0; obs_lat = -1;
        obs_result = -1; obs_found = -1; obs_err = -1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) begin
                obs_busy++;
                obs_guesses.push_back(int'(bus.guess));
            end
            if (bus.done) begin
                obs_done++;
                if (obs_lat < 0) begin
                    obs_lat    = j - 1;
                    obs_result = int'(bus.result);
                    obs_found  = int'(bus.found);
                    obs_err    = int'(bus.err);
                end
            end
            fault_on = (j == fp);
            if (obs_lat >= 0 && j >= obs_lat + 2) break;
        end
        fault_on = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0]      b;
        logic [2:0]      fp;
        logic [2:0]      fpat;
        logic [3:0]      exp_result;
        logic            exp_found;
        logic            exp_err;
        logic [2:0]      exp_lat;
        logic [2:0]      n_g;
        logic [0:4][3:0] g;
    } vec_t;

    vec_t vecs [8];
    logic [2:0] bad_pats [5];

    initial begin
        vecs[0] = '{4'd5,  3'd0, 3'b000, 4'd5,  1'b1, 1'b0, 3'd4, 3'd4, {4'd8, 4'd4,  4'd6,  4'd5,  4'd0}};
        vecs[1] = '{4'd8,  3'd0, 3'b000, 4'd8,  1'b1, 1'b0, 3'd1, 3'd1, {4'd8, 4'd0,  4'd0,  4'd0,  4'd0}};
        vecs[2] = '{4'd0,  3'd0, 3'b000, 4'd0,  1'b1, 1'b0, 3'd5, 3'd5, {4'd8, 4'd4,  4'd2,  4'd1,  4'd0}};
        vecs[3] = '{4'd15, 3'd0, 3'b000, 4'd15, 1'b1, 1'b0, 3'd4, 3'd4, {4'd8, 4'd12, 4'd14, 4'd15, 4'd0}};
        vecs[4] = '{4'd7,  3'd0, 3'b000, 4'd7,  1'b1, 1'b0, 3'd4, 3'd4, {4'd8, 4'd4,  4'd6,  4'd7,  4'd0}};
        vecs[5] = '{4'd5,  3'd2, 3'b110, 4'd0,  1'b0, 1'b1, 3'd2, 3'd2, {4'd8, 4'd4,  4'd0,  4'd0,  4'd0}};
        vecs[6] = '{4'd0,  3'd5, 3'b000, 4'd0,  1'b0, 1'b1, 3'd5, 3'd5, {4'd8, 4'd4,  4'd2,  4'd1,  4'd0}};
        vecs[7] = '{4'd0,  3'd5, 3'b100, 4'd0,  1'b0, 1'b0, 3'd5, 3'd5, {4'd8, 4'd4,  4'd2,  4'd1,  4'd0}};
        bad_pats = '{3'b000, 3'b110, 3'b101, 3'b011, 3'b111};

        bus.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset guess",  int'(bus.guess),  0);
        checkOutput("reset result", int'(bus.result), 0);
        checkOutput("reset found",  int'(bus.found),  0);
        checkOutput("reset err",    int'(bus.err),    0);
        checkOutput("reset busy",   int'(bus.busy),   0);
        checkOutput("reset done",   int'(bus.done),   0);
        rst_n = 1'b1;

        $display("[TB] directed table");
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].b, int'(vecs[v].fp), vecs[v].fpat);
            checkOutput($sformatf("v%0d latency", v), obs_lat, int'(vecs[v].exp_lat));
            checkOutput($sformatf("v%0d result", v), obs_result, int'(vecs[v].exp_result));
            checkOutput($sformatf("v%0d found", v), obs_found, int'(vecs[v].exp_found));
            checkOutput($sformatf("v%0d err", v), obs_err, int'(vecs[v].exp_err));
            checkOutput($sformatf("v%0d done pulses", v), obs_done, 1);
            checkOutput($sformatf("v%0d busy cycles", v), obs_busy, int'(vecs[v].exp_lat));
            checkOutput($sformatf("v%0d probe count", v), obs_guesses.size(), int'(vecs[v].n_g));
            for (int i = 0; i < int'(vecs[v].n_g) && i < obs_guesses.size(); i++)
                checkOutput($sformatf("v%0d guess%0d", v, i + 1), obs_guesses[i], int'(vecs[v].g[i]));
        end

        // A fresh start must clear the fault left by the previous run.
        applyStimulus(4'd5, 2, 3'b110);
        checkOutput("fault err set", obs_err, 1);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("restart clears err", int'(bus.err), 0);
        checkOutput("restart busy", int'(bus.busy), 1);
        begin
            int got = 0;
            for (int j = 0; j < 10 && got == 0; j++) begin
                @(negedge clk);
                if (bus.done) got = 1;
            end
            checkOutput("restart completes", got, 1);
            checkOutput("restart result", int'(bus.result), 5);
            checkOutput("restart found", int'(bus.found), 1);
        end

        $display("[TB] sweep and random");
        for (int b = 0; b < 16; b++) begin
            applyStimulus(4'(b), 0, 3'b000);
            checkOutput($sformatf("sweep b%0d result", b), obs_result, b);
            checkOutput($sformatf("sweep b%0d found", b), obs_found, 1);
            checkOutput($sformatf("sweep b%0d latency", b), obs_lat, model_latency(b));
            checkOutput($sformatf("sweep b%0d done pulses", b), obs_done, 1);
        end
        for (int r = 0; r < 30; r++) begin
            int b, fp, lat, exp_lat;
            logic [2:0] pat;
            b = int'($urandom_range(0, 15));
            fp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            pat = bad_pats[$urandom_range(0, 4)];
            applyStimulus(4'(b), fp, pat);
            lat = model_latency(b);
            if (fp != 0 && fp <= lat) begin
                exp_lat = fp;
                checkOutput($sformatf("rnd%0d err", r), obs_err, 1);
                checkOutput($sformatf("rnd%0d found", r), obs_found, 0);
                checkOutput($sformatf("rnd%0d result", r), obs_result, 0);
            end else begin
                exp_lat = lat;
                checkOutput($sformatf("rnd%0d err", r), obs_err, 0);
                checkOutput($sformatf("rnd%0d found", r), obs_found, 1);
                checkOutput($sformatf("rnd%0d result", r), obs_result, b);
            end
            checkOutput($sformatf("rnd%0d latency", r), obs_lat, exp_lat);
            checkOutput($sformatf("rnd%0d probe count", r), obs_guesses.size(), exp_lat);
            for (int i = 0; i < exp_lat && i < obs_guesses.size(); i++)
                checkOutput($sformatf("rnd%0d guess%0d", r, i + 1), obs_guesses[i], model_guess(b, i + 1));
        end

        $display("[TB] protocol: start held high");
        begin
            int lat, dones, done_at, busy_gap, busy_again, got;
            b_val = 4'd6;
            lat = model_latency(6);
            dones = 0; done_at = -1; busy_gap = -1; busy_again = -1;
            @(negedge clk);
            bus.start = 1'b1;
            for (int j = 1; j <= lat + 3; j++) begin
                @(negedge clk);
                if (j <= lat + 2 && bus.done) begin
                    dones++;
                    if (done_at < 0) done_at = j - 1;
                end
                if (j == lat + 2) busy_gap = int'(bus.busy);
                if (j == lat + 3) busy_again = int'(bus.busy);
            end
            bus.start = 1'b0;
            checkOutput("held start done pulses", dones, 1);
            checkOutput("held start latency", done_at, lat);
            checkOutput("held start idle gap busy", busy_gap, 0);
            checkOutput("held start restart busy", busy_again, 1);
            got = 0;
            for (int j = 0; j < 10 && got == 0; j++) begin
                @(negedge clk);
                if (bus.done) got = 1;
            end
            checkOutput("held start second run done", got, 1);
            checkOutput("held start second result", int'(bus.result), 6);
            @(negedge clk);
        end

        $display("[TB] protocol: reset mid-search");
        begin
            int dones;
            b_val = 4'd5;
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            checkOutput("midreset guess",  int'(bus.guess),  0);
            checkOutput("midreset result", int'(bus.result), 0);
            checkOutput("midreset found",  int'(bus.found),  0);
            checkOutput("midreset err",    int'(bus.err),    0);
            checkOutput("midreset busy",   int'(bus.busy),   0);
            checkOutput("midreset done",   int'(bus.done),   0);
            rst_n = 1'b1;
            dones = 0;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                if (bus.done) dones++;
            end
            checkOutput("midreset no done pulse", dones, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
